// File: rtl/seven_seg_scan_driver_if.sv
// Display bus between a controller and the 7-seg scan driver.
// The controller (master) supplies the value and its load strobe.
// The driver (slave) returns the decoder nibble, the anode enables and the frame/ack pulses.
interface seven_seg_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   value;
  logic                      blank_lz;
  logic [3:0]                digit_code;
  logic [NUM_DIGITS-1:0]     digit_en;
  logic                      frame_start;
  logic                      load_ack;

  modport master (
    output load, value, blank_lz,
    input  digit_code, digit_en, frame_start, load_ack
  );

  modport slave (
    input  load, value, blank_lz,
    output digit_code, digit_en, frame_start, load_ack
  );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed hex driver for a common-anode 7-segment display.
// Each digit slot opens with a blanking gap so the external decoder settles before
// the anode turns on. New values wait in a pending buffer and reach the display
// shadow only at frame boundaries, so a frame never mixes old and new digits.
// Every output is registered from the next-cycle state, so each output reflects
// its own cycle's slot position with no extra lag.
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                     clk,
  input  logic                     reset,
  seven_seg_scan_driver_if.slave   bus
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VAL_W = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [VAL_W-1:0]      r_shadow;
  logic [VAL_W-1:0]      r_pending;
  logic                  r_pending_vld;
  logic                  r_lz_slot;
  logic [3:0]            r_digit_code;
  logic [NUM_DIGITS-1:0] r_digit_en;
  logic                  r_frame_start;
  logic                  r_load_ack;

  logic                  w_slot_end;
  logic                  w_frame_end;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [IDX_W-1:0]      w_idx_nxt;
  logic [VAL_W-1:0]      w_shadow_nxt;
  logic [VAL_W-1:0]      w_pending_nxt;
  logic                  w_pending_vld_nxt;
  logic                  w_lz_nxt;
  logic                  w_upper_zero;
  logic                  w_suppress;
  logic [3:0]            w_code_nxt;
  logic [NUM_DIGITS-1:0] w_en_nxt;
  logic                  w_frame_start_nxt;
  logic                  w_load_ack_nxt;

  // Next-state: slot position, double buffer, leading-zero blanking and outputs for the coming cycle
  always_comb begin
    w_slot_end        = (r_cnt == CNT_LAST);
    w_frame_end       = w_slot_end && (r_idx == IDX_LAST);
    w_cnt_nxt         = w_slot_end ? '0 : r_cnt + 1'b1;
    w_idx_nxt         = r_idx;
    w_shadow_nxt      = r_shadow;
    w_pending_nxt     = r_pending;
    w_pending_vld_nxt = r_pending_vld;
    w_lz_nxt          = r_lz_slot;
    w_upper_zero      = 1'b1;
    w_suppress        = 1'b0;
    w_code_nxt        = 4'd0;
    w_en_nxt          = '1;

    if (w_slot_end) begin
      w_idx_nxt = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      // blanking mode is frozen for a whole slot so the anode never flickers mid-slot
      w_lz_nxt  = bus.blank_lz;
    end

    // A load landing on the boundary edge goes straight to the shadow; otherwise it waits
    if (w_frame_end) begin
      if (bus.load) begin
        w_shadow_nxt = bus.value;
      end else if (r_pending_vld) begin
        w_shadow_nxt = r_pending;
      end
      w_pending_vld_nxt = 1'b0;
    end else if (bus.load) begin
      w_pending_nxt     = bus.value;
      w_pending_vld_nxt = 1'b1;
    end

    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (IDX_W'(k) == w_idx_nxt) begin
        w_code_nxt = w_shadow_nxt[4*k +: 4];
      end
    end

    // Walk down from the top digit; a digit is a leading zero if it and all above are zero
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      w_upper_zero = w_upper_zero & (w_shadow_nxt[4*k +: 4] == 4'd0);
      if (IDX_W'(k) == w_idx_nxt) begin
        w_suppress = w_upper_zero;
      end
    end

    if ((w_cnt_nxt >= CNT_BLANK) && !(w_lz_nxt && w_suppress)) begin
      w_en_nxt = ~(NUM_DIGITS'(1) << w_idx_nxt);
    end

    w_frame_start_nxt = w_frame_end;
    w_load_ack_nxt    = w_frame_end && (bus.load || r_pending_vld);
  end

  // State and output registers; reset clears the buffers too so a stale value never shows
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt         <= '0;
      r_idx         <= '0;
      r_shadow      <= '0;
      r_pending     <= '0;
      r_pending_vld <= 1'b0;
      r_lz_slot     <= 1'b0;
      r_digit_code  <= 4'd0;
      r_digit_en    <= '1;
      r_frame_start <= 1'b0;
      r_load_ack    <= 1'b0;
    end else begin
      r_cnt         <= w_cnt_nxt;
      r_idx         <= w_idx_nxt;
      r_shadow      <= w_shadow_nxt;
      r_pending     <= w_pending_nxt;
      r_pending_vld <= w_pending_vld_nxt;
      r_lz_slot     <= w_lz_nxt;
      r_digit_code  <= w_code_nxt;
      r_digit_en    <= w_en_nxt;
      r_frame_start <= w_frame_start_nxt;
      r_load_ack    <= w_load_ack_nxt;
    end
  end

  assign bus.digit_code  = r_digit_code;
  assign bus.digit_en    = r_digit_en;
  assign bus.frame_start = r_frame_start;
  assign bus.load_ack    = r_load_ack;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: directed scenarios with literal expectations,
// then a randomized run, all compared every cycle against a cycle-count model.
module tb_seven_seg_scan_driver;

  localparam int ND = 4;
  localparam int SD = 8;
  localparam int BL = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  seven_seg_scan_driver_if #(.NUM_DIGITS(ND)) bif();

  seven_seg_scan_driver #(
    .NUM_DIGITS  (ND),
    .SCAN_DIV    (SD),
    .BLANK_CYCLES(BL)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bif)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (time %0t)", name, act, exp, $time);
  endtask

  // Reference model: position in the scan is just elapsed cycles since reset
  bit          m_valid = 1'b0;
  int          m_t;
  logic [15:0] m_sh, m_pend;
  bit          m_pv, m_lz, m_ack, m_fs;

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_t = 0; m_sh = '0; m_pend = '0; m_pv = 0; m_lz = 0;
        m_ack = 0; m_fs = 0; m_valid = 1'b1;
      end else if (m_valid) begin
        bit boundary;
        boundary = (m_t % SD == SD - 1) && ((m_t / SD) % ND == ND - 1);
        m_fs  = boundary;
        m_ack = boundary && (m_pv || bif.load);
        if (boundary) begin
          if (bif.load) m_sh = bif.value;
          else if (m_pv) m_sh = m_pend;
          m_pv = 0;
        end else if (bif.load) begin
          m_pend = bif.value;
          m_pv   = 1;
        end
        if (m_t % SD == SD - 1) m_lz = bif.blank_lz;
        m_t++;
      end
    end
  end

  function automatic logic [ND-1:0] exp_en(input int t, input logic [15:0] sh, input bit lz);
    int c, d;
    c = t % SD;
    d = (t / SD) % ND;
    if (c < BL) return '1;
    if (lz && d > 0 && (sh >> (4 * d)) == 16'd0) return '1;
    return ~(ND'(1) << d);
  endfunction

  // Compare process: every cycle after the first reset
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        int d;
        logic [15:0] sh_shift;
        d = (m_t / SD) % ND;
        sh_shift = m_sh >> (4 * d);
        chk("model digit_code", {28'd0, bif.digit_code}, {28'd0, sh_shift[3:0]});
        chk("model digit_en", {28'd0, bif.digit_en}, {28'd0, exp_en(m_t, m_sh, m_lz)});
        chk("model frame_start", {31'd0, bif.frame_start}, {31'd0, m_fs});
        chk("model load_ack", {31'd0, bif.load_ack}, {31'd0, m_ack});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  int cyc;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic at(input int c);
    while (cyc < c) step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset    = 1'b1;
    bif.load = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic pulse_load(input logic [15:0] v);
    bif.load  = 1'b1;
    bif.value = v;
    step();
    bif.load  = 1'b0;
  endtask

  initial begin
    bif.load     = 1'b0;
    bif.value    = '0;
    bif.blank_lz = 1'b0;

    // 1: plain scan of zeros
    do_reset();
    at(0);  chk("rst en", {28'd0, bif.digit_en}, 32'hF);
            chk("rst code", {28'd0, bif.digit_code}, 32'h0);
            chk("rst fs", {31'd0, bif.frame_start}, 32'h0);
            chk("rst ack", {31'd0, bif.load_ack}, 32'h0);
    at(1);  chk("t1 en c1", {28'd0, bif.digit_en}, 32'hF);
    at(2);  chk("t1 en c2", {28'd0, bif.digit_en}, 32'hE);
    at(9);  chk("t1 en c9", {28'd0, bif.digit_en}, 32'hF);
    at(10); chk("t1 en c10", {28'd0, bif.digit_en}, 32'hD);
    at(26); chk("t1 en c26", {28'd0, bif.digit_en}, 32'h7);
    at(32); chk("t1 fs c32", {31'd0, bif.frame_start}, 32'h1);
            chk("t1 ack c32", {31'd0, bif.load_ack}, 32'h0);

    // 2: single load applied at next frame
    do_reset();
    while (cyc < 5) step();
    pulse_load(16'h1A2F);
    at(31); chk("t2 code c31", {28'd0, bif.digit_code}, 32'h0);
    at(32); chk("t2 ack c32", {31'd0, bif.load_ack}, 32'h1);
            chk("t2 fs c32", {31'd0, bif.frame_start}, 32'h1);
            chk("t2 code d0", {28'd0, bif.digit_code}, 32'hF);
    at(40); chk("t2 code d1", {28'd0, bif.digit_code}, 32'h2);
    at(48); chk("t2 code d2", {28'd0, bif.digit_code}, 32'hA);
    at(56); chk("t2 code d3", {28'd0, bif.digit_code}, 32'h1);

    // 3: last load wins, single ack
    do_reset();
    while (cyc < 10) step();
    pulse_load(16'h1111);
    while (cyc < 20) step();
    pulse_load(16'h2222);
    at(32); chk("t3 ack c32", {31'd0, bif.load_ack}, 32'h1);
            chk("t3 code c32", {28'd0, bif.digit_code}, 32'h2);
    at(33); chk("t3 ack c33", {31'd0, bif.load_ack}, 32'h0);
    at(64); chk("t3 ack c64", {31'd0, bif.load_ack}, 32'h0);

    // 4: load on the boundary edge with leading-zero blanking
    do_reset();
    bif.blank_lz = 1'b1;
    while (cyc < 31) step();
    pulse_load(16'h00F0);
    at(32); chk("t4 ack c32", {31'd0, bif.load_ack}, 32'h1);
            chk("t4 code d0", {28'd0, bif.digit_code}, 32'h0);
    at(34); chk("t4 en d0", {28'd0, bif.digit_en}, 32'hE);
    at(40); chk("t4 code d1", {28'd0, bif.digit_code}, 32'hF);
    at(42); chk("t4 en d1", {28'd0, bif.digit_en}, 32'hD);
    at(50); chk("t4 en d2", {28'd0, bif.digit_en}, 32'hF);
    at(58); chk("t4 en d3", {28'd0, bif.digit_en}, 32'hF);

    // 5: all-zero value with blanking lights only digit 0
    do_reset();
    bif.blank_lz = 1'b1;
    at(2);  chk("t5 en d0", {28'd0, bif.digit_en}, 32'hE);
    at(10); chk("t5 en d1", {28'd0, bif.digit_en}, 32'hF);
    at(18); chk("t5 en d2", {28'd0, bif.digit_en}, 32'hF);
    at(26); chk("t5 en d3", {28'd0, bif.digit_en}, 32'hF);
    at(34); chk("t5 en d0 f2", {28'd0, bif.digit_en}, 32'hE);

    // 6: reset mid-SHOW with a pending value and a coincident load
    bif.blank_lz = 1'b0;
    do_reset();
    while (cyc < 3) step();
    pulse_load(16'h4321);
    at(20); chk("t6 en before rst", {28'd0, bif.digit_en}, 32'hB);
    reset     = 1'b1;
    bif.load  = 1'b1;
    bif.value = 16'hFFFF;
    step();
    reset    = 1'b0;
    bif.load = 1'b0;
    cyc      = 0;
    at(0);  chk("t6 en", {28'd0, bif.digit_en}, 32'hF);
            chk("t6 code", {28'd0, bif.digit_code}, 32'h0);
            chk("t6 fs", {31'd0, bif.frame_start}, 32'h0);
    at(32); chk("t6 ack c32", {31'd0, bif.load_ack}, 32'h0);
            chk("t6 fs c32", {31'd0, bif.frame_start}, 32'h1);
    at(40); chk("t6 code d1", {28'd0, bif.digit_code}, 32'h0);

    // Randomized traffic, checked by the model every cycle
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] v;
      v         = 16'($urandom);
      v         = v >> (4 * $urandom_range(0, 4));
      bif.value = v;
      bif.load  = ($urandom_range(0, 99) < 12);
      if ($urandom_range(0, 39) == 0) bif.blank_lz = ~bif.blank_lz;
      reset     = ($urandom_range(0, 599) == 0);
      step();
    end
    reset    = 1'b0;
    bif.load = 1'b0;
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
